fft_stage_sequencer: RTL and testbench
======================================

FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 Parameter BF_LATENCY, default 3: butterfly datapath read-to-write latency in cycles, legal range 1..7.
REQ-002 Parameter ADDR_W, default 11: memory address width, sized for 2048 points maximum.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 ena_fft  in  1  start request; only a rising edge is acted on (level may be held for several cycles).
REQ-006 stage_number  in  4  log2 of the FFT size; sampled at start.
REQ-007 max_point_fft  in  12  FFT point count N; sampled at start.
REQ-008 bf_stall  in  1  datapath hold; freezes issue, delay line and drain counter.
REQ-009 rd_ena  out  1  butterfly operand read strobe.
REQ-010 rd_addr_a, rd_addr_b  out  ADDR_W  butterfly operand read addresses.
REQ-011 tw_addr  out  ADDR_W-1  twiddle ROM index.
REQ-012 wr_ena  out  1  butterfly result write strobe.
REQ-013 wr_addr_a, wr_addr_b  out  ADDR_W  result write addresses.
REQ-014 stage_level  out  4  current stage index.
REQ-015 busy  out  1  high from start acceptance until the ena_mag cycle inclusive.
REQ-016 ena_mag  out  1  one-cycle pulse: transform complete, magnitude stage may begin.
REQ-017 cfg_err  out  1  one-cycle pulse: start rejected for illegal configuration.

Function
REQ-018 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-019 IDLE: on an ena_fft rising edge, check the configuration.
- Legal configuration is 1 <= stage_number <= 11 and max_point_fft == 2^stage_number.
- If legal, latch stage_number and N, clear stage s and butterfly k, set busy, and go to ISSUE.
- If illegal, pulse cfg_err and stay in IDLE.
REQ-020 ISSUE, each non-stalled cycle:
- rd_ena = 1.
- half = 2^s, pos = k mod half.
- rd_addr_a = ((k >> s) << (s+1)) + pos; rd_addr_b = rd_addr_a + half.
- tw_addr = pos << (stage_number-1-s).
- k increments.
REQ-021 Leaving ISSUE: after issuing k = N/2-1, go to DRAIN with the drain counter loaded to BF_LATENCY.
REQ-022 DRAIN: the counter decrements each non-stalled cycle. At 0:
- if s < stage_number-1: s increments, k clears, go to ISSUE;
- otherwise go to DONE.
REQ-023 DONE: ena_mag = 1 for exactly one cycle, then busy = 0 and the FSM returns to IDLE.
REQ-024 Write path: wr_ena, wr_addr_a and wr_addr_b are rd_ena, rd_addr_a and rd_addr_b delayed by exactly BF_LATENCY non-stalled cycles through a shift register.
REQ-025 bf_stall = 1 forces rd_ena = 0 and wr_ena = 0, and holds all counters, addresses and the delay line unchanged.
REQ-026 Hazard rule: no stage s+1 read is issued before the last stage-s write has been issued.
REQ-027 stage_level = s at all times; it reads 0 in IDLE.
REQ-028 ena_fft edges while busy = 1 are ignored and do not set cfg_err.
REQ-029 Unstalled run time from start acceptance to ena_mag is stage_number*(N/2 + BF_LATENCY) + 1 cycles.
REQ-030 Address arithmetic is unsigned and never exceeds N-1.

Reset
REQ-031 While rst_n = 0, with no clock required:
- FSM = IDLE; s, k, drain counter and delay line cleared;
- all outputs 0;
- the ena_fft edge detector is cleared, so a level already high when reset releases is not a start.
REQ-032 Reset asserted mid-transform aborts it with no ena_mag.

Configuration
REQ-033 Macro FFT_SEQ_BITREV_EN.
- Defined: on the final stage only, wr_addr_a and wr_addr_b are the stage_number-bit bit-reversals of the delayed addresses, so results land in natural order.
- Undefined: write addresses always equal the delayed read addresses (in-place, bit-reversed output order).

Verification
REQ-034 N=8, stage_number=3, BF_LATENCY=3, ena_fft high 4 cycles -> exactly one transform.
- Stage-0 read pairs (0,1)(2,3)(4,5)(6,7); stage-1 (0,2)(1,3)(4,6)(5,7); stage-2 (0,4)(1,5)(2,6)(3,7).
- ena_mag 22 cycles after acceptance.
REQ-035 N=8 run with FFT_SEQ_BITREV_EN defined -> stage-2 write pairs (0,1)(4,5)(2,3)(6,7); with it undefined they equal the read pairs.
REQ-036 stage_number=3, max_point_fft=10 -> cfg_err pulse, busy stays 0, no rd_ena; stage_number=0 gives the same result.
REQ-037 N=16, bf_stall high 5 cycles mid stage 1 -> no strobes during the stall, identical address sequence, ena_mag delayed exactly 5 cycles.
REQ-038 rst_n low mid stage 1, then a new start with N=4 -> all outputs 0 during reset; new run completes with ena_mag at cycle 2*(2+3)+1 = 11.
REQ-039 Second ena_fft rising edge during a run -> ignored; a single ena_mag.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: address and control sequencer for an in-place radix-2
// FFT. Walks stage_number stages of N/2 butterflies, issues operand reads and
// twiddle indices, and replays the read strobes/addresses as write strobes
// after BF_LATENCY unstalled cycles. Each stage waits for its own writes to
// drain before the next stage reads, so no read overtakes a pending write.
// Optional feature macro: FFT_SEQ_BITREV_EN -- bit-reverse the final-stage
// write addresses so results land in natural order.
module fft_stage_sequencer #(
  parameter int BF_LATENCY = 3,
  parameter int ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena_fft,
  input  logic [3:0]        stage_number,
  input  logic [11:0]       max_point_fft,
  input  logic              bf_stall,
  output logic              rd_ena,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ADDR_W-2:0] tw_addr,
  output logic              wr_ena,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b,
  output logic [3:0]        stage_level,
  output logic              busy,
  output logic              ena_mag,
  output logic              cfg_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  logic [3:0]        sn_q;
  logic [3:0]        s_q;
  logic [ADDR_W-1:0] k_q;
  logic [2:0]        drain_q;
  logic              ena_prev;

  logic              rd_ena_q;
  logic [ADDR_W-1:0] rd_a_q;
  logic [ADDR_W-1:0] rd_b_q;
  logic [ADDR_W-2:0] tw_q;

  logic              dl_ena [BF_LATENCY];
  logic [ADDR_W-1:0] dl_a   [BF_LATENCY];
  logic [ADDR_W-1:0] dl_b   [BF_LATENCY];

  logic              rise;
  logic              cfg_ok;
  logic [ADDR_W-1:0] half;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] addr_a_next;
  logic [ADDR_W-2:0] tw_next;
  logic [ADDR_W-1:0] k_last;
  logic [3:0]        s_last;

  assign rise   = ena_fft & ~ena_prev;
  assign cfg_ok = (stage_number >= 4'd1) && (stage_number <= 4'd11) &&
                  (max_point_fft == (12'd1 << stage_number));

  // Butterfly k of stage s: group (k >> s) of span 2^(s+1), offset k mod 2^s.
  assign s_last      = sn_q - 4'd1;
  assign half        = ADDR_W'(1) << s_q;
  assign pos         = k_q & (half - ADDR_W'(1));
  assign addr_a_next = ((k_q >> s_q) << (s_q + 4'd1)) + pos;
  assign tw_next     = (ADDR_W-1)'(pos << (s_last - s_q));
  assign k_last      = (ADDR_W'(1) << s_last) - ADDR_W'(1);

  // Main control FSM: start check, issue walk, per-stage drain, completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sn_q     <= '0;
      s_q      <= '0;
      k_q      <= '0;
      drain_q  <= '0;
      // Seeded high so a level already asserted at reset release is not a start.
      ena_prev <= 1'b1;
      rd_ena_q <= 1'b0;
      rd_a_q   <= '0;
      rd_b_q   <= '0;
      tw_q     <= '0;
      busy     <= 1'b0;
      ena_mag  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      ena_prev <= ena_fft;
      cfg_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            if (cfg_ok) begin
              sn_q  <= stage_number;
              s_q   <= '0;
              k_q   <= '0;
              busy  <= 1'b1;
              state <= ISSUE;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (!bf_stall) begin
            rd_ena_q <= 1'b1;
            rd_a_q   <= addr_a_next;
            rd_b_q   <= addr_a_next + half;
            tw_q     <= tw_next;
            if (k_q == k_last) begin
              k_q     <= '0;
              drain_q <= 3'(BF_LATENCY);
              state   <= DRAIN;
            end else begin
              k_q <= k_q + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (!bf_stall) begin
            rd_ena_q <= 1'b0;
            rd_a_q   <= '0;
            rd_b_q   <= '0;
            tw_q     <= '0;
            if (drain_q == 3'd1) begin
              drain_q <= '0;
              if (s_q < s_last) begin
                s_q   <= s_q + 4'd1;
                k_q   <= '0;
                state <= ISSUE;
              end else begin
                ena_mag <= 1'b1;
                state   <= DONE;
              end
            end else begin
              drain_q <= drain_q - 3'd1;
            end
          end
        end
        DONE: begin
          ena_mag <= 1'b0;
          busy    <= 1'b0;
          s_q     <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-to-write delay line; frozen whenever the datapath is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BF_LATENCY; i++) begin
        dl_ena[i] <= 1'b0;
        dl_a[i]   <= '0;
        dl_b[i]   <= '0;
      end
    end else if (!bf_stall) begin
      dl_ena[0] <= rd_ena_q;
      dl_a[0]   <= rd_a_q;
      dl_b[0]   <= rd_b_q;
      for (int i = BF_LATENCY - 1; i > 0; i--) begin
        dl_ena[i] <= dl_ena[i-1];
        dl_a[i]   <= dl_a[i-1];
        dl_b[i]   <= dl_b[i-1];
      end
    end
  end

  assign rd_ena      = rd_ena_q & ~bf_stall;
  assign rd_addr_a   = rd_a_q;
  assign rd_addr_b   = rd_b_q;
  assign tw_addr     = tw_q;
  assign wr_ena      = dl_ena[BF_LATENCY-1] & ~bf_stall;
  assign stage_level = s_q;

`ifdef FFT_SEQ_BITREV_EN
  logic rd_last_q;
  logic dl_last [BF_LATENCY];

  function automatic logic [ADDR_W-1:0] bit_rev(input logic [ADDR_W-1:0] a,
                                                input logic [3:0] n);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (i < int'(n)) r[i] = a[int'(n) - 1 - i];
    end
    return r;
  endfunction

  // Final-stage tag travels with each read so writes know when to reorder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_last_q <= 1'b0;
      for (int i = 0; i < BF_LATENCY; i++) dl_last[i] <= 1'b0;
    end else if (!bf_stall) begin
      rd_last_q  <= (state == ISSUE) && (s_q == s_last);
      dl_last[0] <= rd_last_q;
      for (int i = BF_LATENCY - 1; i > 0; i--) dl_last[i] <= dl_last[i-1];
    end
  end

  assign wr_addr_a = dl_last[BF_LATENCY-1] ? bit_rev(dl_a[BF_LATENCY-1], sn_q)
                                           : dl_a[BF_LATENCY-1];
  assign wr_addr_b = dl_last[BF_LATENCY-1] ? bit_rev(dl_b[BF_LATENCY-1], sn_q)
                                           : dl_b[BF_LATENCY-1];
`else
  assign wr_addr_a = dl_a[BF_LATENCY-1];
  assign wr_addr_b = dl_b[BF_LATENCY-1];
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer: a scoreboard of expected read
// and write transactions built from a group/offset model of the radix-2 walk,
// plus per-scenario tasks for reset, config rejection, stall, abort and
// ignored restart.
module tb_fft_stage_sequencer;
  localparam int LAT = 3;
  localparam int AW  = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena_fft = 1'b0;
  logic [3:0]    stage_number = '0;
  logic [11:0]   max_point_fft = '0;
  logic          bf_stall = 1'b0;
  logic          rd_ena;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [AW-2:0] tw_addr;
  logic          wr_ena;
  logic [AW-1:0] wr_addr_a, wr_addr_b;
  logic [3:0]    stage_level;
  logic          busy, ena_mag, cfg_err;

  fft_stage_sequencer #(.BF_LATENCY(LAT), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ena_fft(ena_fft), .stage_number(stage_number),
    .max_point_fft(max_point_fft), .bf_stall(bf_stall), .rd_ena(rd_ena),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_ena(wr_ena), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .stage_level(stage_level), .busy(busy), .ena_mag(ena_mag), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int tw;
    int need;
  } txn_t;

  txn_t rdq[$];
  txn_t wrq[$];
  txn_t mon_r, mon_w;

  int checks = 0;
  int passes = 0;
  int busy_cnt, busy_seen, mag_cnt, mag_at, cfg_cnt, rd_cnt, wr_done;

  function automatic int brev(input int x, input int w);
    int r;
    r = 0;
    for (int i = 0; i < w; i++) if ((x >> i) & 1) r |= (1 << (w - 1 - i));
    return r;
  endfunction

  function automatic logic [63:0] all_out();
    return 64'({rd_ena, rd_addr_a, rd_addr_b, tw_addr, wr_ena, wr_addr_a,
                wr_addr_b, stage_level, busy, ena_mag, cfg_err});
  endfunction

  // Expected transactions: butterflies enumerated by group, then offset.
  task automatic push_expected(input int sn);
    int n, half;
    txn_t e, w;
    n = 1 << sn;
    for (int st = 0; st < sn; st++) begin
      half = 1 << st;
      for (int g = 0; g < n; g += 2 * half) begin
        for (int j = 0; j < half; j++) begin
          e.a = g + j;
          e.b = g + j + half;
          e.tw = j * (n / (2 * half));
          e.need = (g == 0 && j == 0) ? st * (n / 2) : 0;
          rdq.push_back(e);
          w = e;
`ifdef FFT_SEQ_BITREV_EN
          if (st == sn - 1) begin
            w.a = brev(e.a, sn);
            w.b = brev(e.b, sn);
          end
`endif
          wrq.push_back(w);
        end
      end
    end
  endtask

  // Monitor: counts events and pops the scoreboard on every strobe.
  always @(negedge clk) begin
    if (busy) begin
      busy_cnt++;
      busy_seen++;
    end
    if (ena_mag) begin
      mag_cnt++;
      mag_at = busy_cnt;
    end
    if (cfg_err) cfg_cnt++;
    if (bf_stall) begin
      checks++;
      if (rd_ena !== 1'b0 || wr_ena !== 1'b0)
        $display("FAIL stall_strobe: rd_ena=%b wr_ena=%b required 0/0", rd_ena, wr_ena);
      else passes++;
    end
    if (rd_ena === 1'b1) begin
      rd_cnt++;
      checks++;
      if (rdq.size() == 0) begin
        $display("FAIL rd_unexpected: a=%0d b=%0d required no read", rd_addr_a, rd_addr_b);
      end else begin
        mon_r = rdq.pop_front();
        if (rd_addr_a !== AW'(mon_r.a) || rd_addr_b !== AW'(mon_r.b) ||
            tw_addr !== (AW-1)'(mon_r.tw))
          $display("FAIL rd_addr: got (%0d,%0d,tw %0d) required (%0d,%0d,tw %0d)",
                   rd_addr_a, rd_addr_b, tw_addr, mon_r.a, mon_r.b, mon_r.tw);
        else passes++;
        if (mon_r.need > 0) begin
          checks++;
          if (wr_done < mon_r.need)
            $display("FAIL hazard: writes done %0d required >= %0d before next stage read",
                     wr_done, mon_r.need);
          else passes++;
        end
      end
    end
    if (wr_ena === 1'b1) begin
      wr_done++;
      checks++;
      if (wrq.size() == 0) begin
        $display("FAIL wr_unexpected: a=%0d b=%0d required no write", wr_addr_a, wr_addr_b);
      end else begin
        mon_w = wrq.pop_front();
        if (wr_addr_a !== AW'(mon_w.a) || wr_addr_b !== AW'(mon_w.b))
          $display("FAIL wr_addr: got (%0d,%0d) required (%0d,%0d)",
                   wr_addr_a, wr_addr_b, mon_w.a, mon_w.b);
        else passes++;
      end
    end
  end

  task automatic start(input int sn, input int n, input int hold, input bit legal);
    busy_cnt = 0; busy_seen = 0; mag_cnt = 0; mag_at = 0;
    cfg_cnt = 0; rd_cnt = 0; wr_done = 0;
    if (legal) push_expected(sn);
    @(posedge clk); #1;
    stage_number  = 4'(sn);
    max_point_fft = 12'(n);
    ena_fft       = 1'b1;
    repeat (hold) @(posedge clk);
    #1 ena_fft = 1'b0;
  endtask

  task automatic finish_run(input int exp_cyc, input string nm);
    for (int i = 0; i < exp_cyc + 100 && mag_cnt == 0; i++) @(posedge clk);
    repeat (LAT + 4) @(posedge clk);
    #1;
    checks++;
    if (mag_cnt !== 1) $display("FAIL %s_mag_count: got %0d required 1", nm, mag_cnt);
    else passes++;
    checks++;
    if (mag_at !== exp_cyc) $display("FAIL %s_latency: got %0d required %0d", nm, mag_at, exp_cyc);
    else passes++;
    checks++;
    if (rdq.size() != 0 || wrq.size() != 0)
      $display("FAIL %s_scoreboard: left rd %0d wr %0d required 0/0", nm, rdq.size(), wrq.size());
    else passes++;
    checks++;
    if (busy !== 1'b0 || stage_level !== 4'd0)
      $display("FAIL %s_idle: busy=%b stage_level=%0d required 0/0", nm, busy, stage_level);
    else passes++;
    rdq.delete();
    wrq.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena_fft = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (all_out() !== 64'd0) $display("FAIL reset_outputs: got %h required 0", all_out());
    else passes++;
    busy_seen = 0; cfg_cnt = 0;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (busy_seen !== 0 || cfg_cnt !== 0)
      $display("FAIL reset_held_level: busy cycles %0d cfg_err %0d required 0/0", busy_seen, cfg_cnt);
    else passes++;
    ena_fft = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    start(3, 8, 4, 1'b1);
    finish_run(22, "n8");
  endtask

  task automatic test_sizes();
    start(1, 2, 1, 1'b1);
    finish_run(5, "n2");
    start(2, 4, 2, 1'b1);
    finish_run(11, "n4");
    start(11, 2048, 1, 1'b1);
    finish_run(11 * (1024 + LAT) + 1, "n2048");
  endtask

  task automatic test_cfg_err();
    start(3, 10, 2, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (cfg_cnt !== 1 || busy_seen !== 0 || rd_cnt !== 0)
      $display("FAIL cfg_bad_n: cfg_err %0d busy %0d reads %0d required 1/0/0", cfg_cnt, busy_seen, rd_cnt);
    else passes++;
    start(0, 1, 2, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (cfg_cnt !== 1 || busy_seen !== 0 || rd_cnt !== 0)
      $display("FAIL cfg_stage0: cfg_err %0d busy %0d reads %0d required 1/0/0", cfg_cnt, busy_seen, rd_cnt);
    else passes++;
  endtask

  task automatic test_stall();
    start(4, 16, 2, 1'b1);
    for (int i = 0; i < 200 && stage_level != 4'd1; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1 bf_stall = 1'b1;
    repeat (5) @(posedge clk);
    #1 bf_stall = 1'b0;
    finish_run(4 * (8 + LAT) + 1 + 5, "stall");
  endtask

  task automatic test_reset_mid();
    start(3, 8, 2, 1'b1);
    for (int i = 0; i < 200 && stage_level != 4'd1; i++) @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (all_out() !== 64'd0) $display("FAIL abort_outputs: got %h required 0", all_out());
    else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (all_out() !== 64'd0 || mag_cnt !== 0)
      $display("FAIL abort_hold: outputs %h ena_mag %0d required 0/0", all_out(), mag_cnt);
    else passes++;
    rdq.delete();
    wrq.delete();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    start(2, 4, 2, 1'b1);
    finish_run(11, "after_abort");
  endtask

  task automatic test_back_to_back();
    start(3, 8, 2, 1'b1);
    repeat (8) @(posedge clk);
    #1 ena_fft = 1'b1;
    repeat (3) @(posedge clk);
    #1 ena_fft = 1'b0;
    finish_run(22, "restart_ignored");
    checks++;
    if (cfg_cnt !== 0) $display("FAIL restart_cfg_err: got %0d required 0", cfg_cnt);
    else passes++;
    start(3, 8, 1, 1'b1);
    finish_run(22, "second_run");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sizes();
    test_cfg_err();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
